// File: rtl/text_wr_sched_if.sv
// Requester and RAM-write bundle for text_wr_sched: packed per-requester
// valid/ready write requests in, registered character-RAM write port out.
interface text_wr_sched_if #(
  parameter int NREQ = 2,
  parameter int AW   = 9
);
  logic [NREQ-1:0]   req_valid;
  logic [5*NREQ-1:0] req_col;
  logic [4*NREQ-1:0] req_row;
  logic [8*NREQ-1:0] req_char;
  logic [NREQ-1:0]   req_ready;
  logic              ram_we;
  logic [AW-1:0]     ram_addr;
  logic [7:0]        ram_wdata;

  modport master (
    output req_valid, req_col, req_row, req_char,
    input  req_ready, ram_we, ram_addr, ram_wdata
  );

  modport slave (
    input  req_valid, req_col, req_row, req_char,
    output req_ready, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/text_wr_sched.sv
// Round-robin write scheduler for the text-mode character RAM, with a full-screen clear sequencer.
// Optional CLEAR_ON_RESET_EN: run one full clear on the first clock edge after reset release.
module text_wr_sched #(
  parameter int COLS = 20,
  parameter int ROWS = 15,
  parameter int NREQ = 2,
  parameter int AW   = 9
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clr_req,
  text_wr_sched_if.slave   bus,
  output logic             busy,
  output logic             err
);

  localparam int          PW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int          CELLS = COLS * ROWS;
  localparam logic [7:0]  SPACE = 8'h20;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t          r_state;
  logic [PW-1:0]   r_rr_ptr;
  logic [AW-1:0]   r_clr_cnt;
  logic            r_ram_we;
  logic [AW-1:0]   r_ram_addr;
  logic [7:0]      r_ram_wdata;
  logic            r_busy;
  logic            r_err;

  logic            w_found;
  logic [PW-1:0]   w_gidx;
  logic [4:0]      w_col;
  logic [3:0]      w_row;
  logic [7:0]      w_char;
  logic [NREQ-1:0] w_ready;
  logic            w_hs;
  logic [PW-1:0]   w_rr_next;
  logic [AW:0]     w_addr_full;
  logic            w_in_range;
  logic            w_boot;
  logic            w_clr_start;

`ifdef CLEAR_ON_RESET_EN
  logic r_boot;

  // One-shot flag that requests a clear on the first edge after reset release.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_boot <= 1'b1;
    end else begin
      r_boot <= 1'b0;
    end
  end

  assign w_boot = r_boot;
`else
  assign w_boot = 1'b0;
`endif

  assign w_clr_start = clr_req | w_boot;

  // Rotating priority search starting at r_rr_ptr.
  always_comb begin : arb_p
    int v_idx;
    v_idx   = 0;
    w_found = 1'b0;
    w_gidx  = '0;
    w_col   = 5'd0;
    w_row   = 4'd0;
    w_char  = 8'h00;
    for (int k = 0; k < NREQ; k++) begin
      v_idx = int'(r_rr_ptr) + k;
      if (v_idx >= NREQ) begin
        v_idx = v_idx - NREQ;
      end else begin
        v_idx = v_idx;
      end
      if (!w_found && bus.req_valid[v_idx]) begin
        w_found = 1'b1;
        w_gidx  = PW'(v_idx);
        w_col   = bus.req_col[5*v_idx +: 5];
        w_row   = bus.req_row[4*v_idx +: 4];
        w_char  = bus.req_char[8*v_idx +: 8];
      end else begin
        w_found = w_found;
      end
    end
  end

  // Grants are only offered while idle and no clear is starting this cycle.
  always_comb begin
    w_ready = '0;
    if ((r_state == S_IDLE) && !w_clr_start && w_found) begin
      w_ready[w_gidx] = 1'b1;
    end else begin
      w_ready = '0;
    end
  end

  assign w_hs        = |(w_ready & bus.req_valid);
  assign w_rr_next   = (w_gidx == PW'(NREQ - 1)) ? '0 : (w_gidx + PW'(1));
  assign w_addr_full = (AW+1)'(w_row) * (AW+1)'(COLS) + (AW+1)'(w_col);
  assign w_in_range  = ((AW+1)'(w_col) < (AW+1)'(COLS)) &&
                       ((AW+1)'(w_row) < (AW+1)'(ROWS)) &&
                       (w_addr_full < (AW+1)'(CELLS));

  // Scheduler FSM with registered RAM write port, busy and err.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_clr_cnt   <= '0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= 8'h00;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_clr_start) begin
            // Address 0 is issued on the start edge so busy spans exactly CELLS cycles.
            r_state     <= S_CLEAR;
            r_busy      <= 1'b1;
            r_clr_cnt   <= '0;
            r_ram_we    <= 1'b1;
            r_ram_addr  <= '0;
            r_ram_wdata <= SPACE;
            r_err       <= 1'b0;
          end else if (w_hs) begin
            r_rr_ptr <= w_rr_next;
            r_ram_we <= w_in_range;
            r_err    <= ~w_in_range;
            if (w_in_range) begin
              r_ram_addr  <= AW'(w_addr_full);
              r_ram_wdata <= w_char;
            end
          end else begin
            r_ram_we <= 1'b0;
            r_err    <= 1'b0;
          end
        end
        S_CLEAR: begin
          r_err <= 1'b0;
          if (r_clr_cnt == AW'(CELLS - 1)) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_ram_we <= 1'b0;
          end else begin
            r_clr_cnt   <= r_clr_cnt + AW'(1);
            r_ram_we    <= 1'b1;
            r_ram_addr  <= r_clr_cnt + AW'(1);
            r_ram_wdata <= SPACE;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_busy   <= 1'b0;
          r_ram_we <= 1'b0;
          r_err    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.ram_we    = r_ram_we;
  assign bus.ram_addr  = r_ram_addr;
  assign bus.ram_wdata = r_ram_wdata;
  assign busy          = r_busy;
  assign err           = r_err;

endmodule
